// File: rtl/fetch_assembler.sv
// Byte-serial Y86 fetch stage: walks instruction memory one byte per cycle,
// assembles one instruction and hands its decoded fields to decode over valid/ready.
module fetch_assembler #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] mem_addr,
  input  logic [7:0]  mem_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] pc_out,
  output logic [3:0]  icode,
  output logic [3:0]  ifun,
  output logic [3:0]  rA,
  output logic [3:0]  rB,
  output logic [63:0] valC,
  output logic [63:0] valP,
  output logic [2:0]  stat,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, STOP} state_t;

  state_t      state_r;
  state_t      state_s;
  logic [63:0] ptr_r;
  logic [63:0] base_r;
  logic [3:0]  k_r;

  logic        adr_err_s;
  logic        bad_s;
  logic        last_s;
  logic [3:0]  cur_ic_s;
  logic [3:0]  cidx_s;

  function automatic logic [3:0] instr_len(input logic [3:0] ic);
    case (ic)
      4'h0, 4'h1, 4'h9:               instr_len = 4'd1;
      4'h2, 4'h6, 4'hA, 4'hB:         instr_len = 4'd2;
      4'h7, 4'h8:                     instr_len = 4'd9;
      4'h3, 4'h4, 4'h5:               instr_len = 4'd10;
      default:                        instr_len = 4'd1;
    endcase
  endfunction

  function automatic logic bad_instr(input logic [3:0] ic, input logic [3:0] fn);
    case (ic)
      4'h6:                           bad_instr = (fn > 4'h3);
      4'h2, 4'h7:                     bad_instr = (fn > 4'h6);
      4'hC, 4'hD, 4'hE, 4'hF:         bad_instr = 1'b1;
      default:                        bad_instr = (fn != 4'h0);
    endcase
  endfunction

  function automatic logic has_reg(input logic [3:0] ic);
    case (ic)
      4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: has_reg = 1'b1;
      default:                                  has_reg = 1'b0;
    endcase
  endfunction

  // Byte index of constant byte 0 within the instruction; 0 means no constant.
  function automatic logic [1:0] const_ofs(input logic [3:0] ic);
    case (ic)
      4'h7, 4'h8:                     const_ofs = 2'd1;
      4'h3, 4'h4, 4'h5:               const_ofs = 2'd2;
      default:                        const_ofs = 2'd0;
    endcase
  endfunction

  assign mem_addr = ((state_r == FETCH) || (state_r == HOLD)) ? ptr_r : 64'd0;
  assign busy     = (state_r == FETCH);

  // Per-cycle fetch decisions derived from the current byte and pointer.
  always_comb begin
    adr_err_s = (ptr_r >= 64'(MEM_BYTES));
    cur_ic_s  = (k_r == 4'd0) ? mem_byte[7:4] : icode;
    bad_s     = (k_r == 4'd0) && bad_instr(mem_byte[7:4], mem_byte[3:0]);
    last_s    = bad_s || ((k_r + 4'd1) == instr_len(cur_ic_s));
    cidx_s    = k_r - {2'b00, const_ofs(icode)};
  end

  // Next-state logic; redirect overrides every other transition.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:  state_s = IDLE;
      FETCH: begin
        if (adr_err_s || last_s) begin
          state_s = HOLD;
        end else begin
          state_s = FETCH;
        end
      end
      HOLD: begin
        if (out_valid && out_ready) begin
          state_s = (stat == 3'd1) ? FETCH : STOP;
        end else begin
          state_s = HOLD;
        end
      end
      STOP:    state_s = STOP;
      default: state_s = IDLE;
    endcase
    if (redirect_valid) begin
      state_s = FETCH;
    end else begin
      state_s = state_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Fetch pointer, byte counter and assembled instruction fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r     <= 64'd0;
      base_r    <= 64'd0;
      k_r       <= 4'd0;
      out_valid <= 1'b0;
      pc_out    <= 64'd0;
      icode     <= 4'd0;
      ifun      <= 4'd0;
      rA        <= 4'd0;
      rB        <= 4'd0;
      valC      <= 64'd0;
      valP      <= 64'd0;
      stat      <= 3'd1;
    end else if (redirect_valid) begin
      ptr_r     <= redirect_pc;
      base_r    <= redirect_pc;
      k_r       <= 4'd0;
      out_valid <= 1'b0;
    end else begin
      case (state_r)
        FETCH: begin
          if (adr_err_s) begin
            // Bad address aborts the instruction; the returned byte is ignored.
            stat      <= 3'd3;
            valP      <= ptr_r;
            out_valid <= 1'b1;
            if (k_r == 4'd0) begin
              pc_out <= base_r;
              icode  <= 4'd0;
              ifun   <= 4'd0;
              rA     <= 4'hF;
              rB     <= 4'hF;
              valC   <= 64'd0;
            end
          end else begin
            ptr_r <= ptr_r + 64'd1;
            k_r   <= k_r + 4'd1;
            if (k_r == 4'd0) begin
              pc_out <= base_r;
              icode  <= mem_byte[7:4];
              ifun   <= mem_byte[3:0];
              rA     <= 4'hF;
              rB     <= 4'hF;
              valC   <= 64'd0;
              stat   <= bad_s ? 3'd4 : ((mem_byte[7:4] == 4'h0) ? 3'd2 : 3'd1);
            end else if (has_reg(icode) && (k_r == 4'd1)) begin
              rA <= mem_byte[7:4];
              rB <= mem_byte[3:0];
            end else if (const_ofs(icode) != 2'd0) begin
              valC[{cidx_s[2:0], 3'b000} +: 8] <= mem_byte;
            end
            if (last_s) begin
              out_valid <= 1'b1;
              valP      <= ptr_r + 64'd1;
            end
          end
        end
        HOLD: begin
          if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (stat == 3'd1) begin
              ptr_r  <= valP;
              base_r <= valP;
              k_r    <= 4'd0;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_assembler.sv
// Self-checking bench for fetch_assembler: directed scenarios plus random programs
// compared against a table-driven Y86 instruction model.
module tb_fetch_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic [63:0] mem_addr;
  logic [7:0]  mem_byte;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] pc_out;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;
  logic        busy;

  logic [7:0]  mem [0:255];
  int          n_assert = 0;
  int          n_fail = 0;

  int lens  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  int maxfn [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

  typedef struct packed {
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pc;
    logic [2:0]  stat;
    logic [7:0]  cycles;
  } exp_t;

  always #5 clk = ~clk;

  always_comb mem_byte = (mem_addr < 64'd256) ? mem[mem_addr[7:0]] : 8'hA5;

  fetch_assembler #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_addr(mem_addr), .mem_byte(mem_byte), .out_valid(out_valid), .out_ready(out_ready),
    .pc_out(pc_out), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC),
    .valP(valP), .stat(stat), .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t model(input logic [63:0] pc);
    exp_t        e;
    logic [7:0]  b [10];
    logic [63:0] a;
    int          len;
    int          ofs;
    e = '0;
    e.pc = pc; e.ra = 4'hF; e.rb = 4'hF; e.stat = 3'd1;
    for (int i = 0; i < 10; i++) b[i] = 8'd0;
    if (pc >= 64'd128) begin
      e.stat = 3'd3; e.valp = pc; e.cycles = 8'd1;
      return e;
    end
    b[0] = mem[pc[7:0]];
    e.icode = b[0][7:4];
    e.ifun  = b[0][3:0];
    if (e.icode > 4'd11 || int'(e.ifun) > maxfn[e.icode]) begin
      e.stat = 3'd4; e.valp = pc + 64'd1; e.cycles = 8'd1;
      return e;
    end
    if (e.icode == 4'd0) e.stat = 3'd2;
    len = lens[e.icode];
    for (int i = 1; i < len; i++) begin
      a = pc + 64'(i);
      if (a >= 64'd128) begin
        e.stat = 3'd3; e.valp = a; e.cycles = 8'(i + 1);
        return e;
      end
      b[i] = mem[a[7:0]];
    end
    if (len == 2 || len == 10) begin
      e.ra = b[1][7:4];
      e.rb = b[1][3:0];
    end
    ofs = (len == 9) ? 1 : 2;
    if (len >= 9) begin
      for (int j = 0; j < 8; j++) e.valc = e.valc | (64'(b[ofs + j]) << (8 * j));
    end
    e.valp = pc + 64'(len);
    e.cycles = 8'(len);
    return e;
  endfunction

  task automatic check_fields(input exp_t e);
    chk("pc_out", pc_out, e.pc);
    chk("icode", 64'(icode), 64'(e.icode));
    chk("ifun", 64'(ifun), 64'(e.ifun));
    chk("stat", 64'(stat), 64'(e.stat));
    chk("valP", valP, e.valp);
    if (e.stat != 3'd3) begin
      chk("rA", 64'(rA), 64'(e.ra));
      chk("rB", 64'(rB), 64'(e.rb));
      chk("valC", valC, e.valc);
    end
  endtask

  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1'b1;
    redirect_pc = pc;
    step();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_valid(input exp_t e);
    int c;
    c = 0;
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && c < 20) begin
      step();
      c++;
    end
    chk("out_valid", 64'(out_valid), 64'd1);
    chk("latency", 64'(c), 64'(e.cycles));
    check_fields(e);
  endtask

  task automatic run_instr(input exp_t e, input int hold);
    logic [63:0] addr0;
    wait_valid(e);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("hold_valid", 64'(out_valid), 64'd1);
      check_fields(e);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("accept_clears", 64'(out_valid), 64'd0);
    if (e.stat != 3'd1) begin
      addr0 = mem_addr;
      for (int s = 0; s < 3; s++) begin
        step();
        chk("stop_addr", mem_addr, addr0);
        chk("stop_busy", 64'(busy), 64'd0);
        chk("stop_valid", 64'(out_valid), 64'd0);
      end
    end else begin
      chk("next_addr", mem_addr, e.valp);
      chk("next_busy", 64'(busy), 64'd1);
    end
  endtask

  initial begin
    exp_t        e;
    logic [63:0] pc;
    int          a;
    int          ic;
    int          ics [11] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11};

    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'd0; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    step(); step();
    rst = 1'b0;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_stat", 64'(stat), 64'd1);
    chk("rst_icode", 64'(icode), 64'd0);
    chk("rst_rA", 64'(rA), 64'd0);
    chk("rst_valC", valC, 64'd0);
    chk("rst_valP", valP, 64'd0);
    chk("rst_addr", mem_addr, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    step(); step();
    chk("idle_busy", 64'(busy), 64'd0);

    // Directed program from the test plan
    mem[0] = 8'h60; mem[1] = 8'h22;
    mem[2] = 8'h80; mem[3] = 8'h0e;
    for (int i = 4; i <= 10; i++) mem[i] = 8'h00;
    mem[14] = 8'h30; mem[15] = 8'hf9; mem[16] = 8'h45;
    for (int i = 17; i <= 23; i++) mem[i] = 8'h00;
    mem[24] = 8'h10; mem[25] = 8'h00;

    do_redirect(64'd0);
    chk("fetch_busy", 64'(busy), 64'd1);
    wait_valid(model(64'd0));
    chk("tp1_rA", 64'(rA), 64'd2);
    chk("tp1_valP", valP, 64'd2);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    run_instr(model(64'd2), 0);
    do_redirect(64'd14);
    wait_valid(model(64'd14));
    chk("tp3_valC", valC, 64'h45);
    for (int h = 0; h < 5; h++) begin
      step();
      chk("tp3_hold", 64'(out_valid), 64'd1);
      check_fields(model(64'd14));
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    chk("tp3_next", mem_addr, 64'd24);
    run_instr(model(64'd24), 0);
    run_instr(model(64'd25), 1);

    // Redirect in the middle of a 10-byte fetch
    mem[8'h40] = 8'h10; mem[8'h41] = 8'hC0;
    do_redirect(64'd14);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("partial_valid", 64'(out_valid), 64'd0);
    end
    do_redirect(64'h40);
    chk("redir_valid", 64'(out_valid), 64'd0);
    chk("redir_addr", mem_addr, 64'h40);
    run_instr(model(64'h40), 0);
    run_instr(model(64'h41), 0);

    // Address error at the top of memory
    mem[127] = 8'h60;
    do_redirect(64'd127);
    wait_valid(model(64'd127));
    chk("adr_stat", 64'(stat), 64'd3);
    chk("adr_valP", valP, 64'd128);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      chk("adr_stop_addr", mem_addr, 64'd0);
      chk("adr_stop_valid", 64'(out_valid), 64'd0);
    end

    // Redirect wins over a simultaneous handshake
    do_redirect(64'd0);
    wait_valid(model(64'd0));
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 64'd14;
    step();
    out_ready = 1'b0; redirect_valid = 1'b0;
    chk("ovr_valid", 64'(out_valid), 64'd0);
    chk("ovr_addr", mem_addr, 64'd14);
    run_instr(model(64'd14), 0);

    // Random programs
    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      a = $urandom_range(0, 100);
      pc = 64'(a);
      while (a < 128) begin
        if ($urandom_range(0, 9) == 0) begin
          ic = 1;
          mem[a] = 8'($urandom);
        end else begin
          ic = ics[$urandom_range(0, 10)];
          mem[a] = {4'(ic), 4'($urandom_range(0, maxfn[ic]))};
        end
        a = a + lens[ic];
      end
      do_redirect(pc);
      for (int n = 0; n < 15; n++) begin
        e = model(pc);
        run_instr(e, $urandom_range(0, 2));
        if (e.stat != 3'd1) break;
        pc = e.valp;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_assembler.md
Name: fetch_assembler

Overview:
- Byte-serial fetch stage for the Y86 pipeline; sits directly downstream of the byte-wide instruction memory.
- Drives one byte address per cycle, collects the 1-10 bytes of one Y86 instruction, and splits them into icode/ifun/rA/rB/valC/valP.
- Presents the decoded instruction and its status to the decode stage over a valid/ready handshake.
- Redirect input (start, jumps, mispredicts) restarts fetch at any PC.

Parameters:
- MEM_BYTES, 128, instruction-memory size; any byte address >= MEM_BYTES is an address error.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- redirect_valid  input  1  load redirect_pc and restart fetch.
- redirect_pc  input  64  new fetch PC.
- mem_addr  output  64  byte address to instruction memory.
- mem_byte  input  8  byte returned combinationally for mem_addr.
- out_valid  output  1  instruction fields valid.
- out_ready  input  1  decode accepts this cycle.
- pc_out  output  64  address of byte 0 of the instruction.
- icode  output  4  byte0[7:4].
- ifun  output  4  byte0[3:0].
- rA  output  4  byte1[7:4], or 4'hF if there is no register byte.
- rB  output  4  byte1[3:0], or 4'hF if there is no register byte.
- valC  output  64  little-endian constant, or 0 if there is none.
- valP  output  64  pc_out + instruction length.
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- busy  output  1  state is FETCH.

Behaviour:
- States: IDLE, FETCH, HOLD, STOP.
- Reset:
  - state=IDLE, out_valid=0, all field outputs 0, stat=1.
  - Internal byte pointer ptr=0, byte count k=0.
- mem_addr = ptr, combinational from the register; outputs are 0 in IDLE/STOP.
- IDLE: wait for redirect_valid.
- Redirect (any non-reset cycle, priority over everything else):
  - Discard partial bytes; out_valid<=0.
  - ptr<=redirect_pc, base<=redirect_pc, k<=0, state<=FETCH.
  - A handshake in the same cycle is overridden, i.e. the instruction is dropped.
- FETCH: one byte per cycle; ptr<=ptr+1, k<=k+1.
- Instruction lengths by icode:
  - 0, 1, 9: 1 byte.
  - 2, 6, A, B: 2 bytes.
  - 7, 8: 9 bytes.
  - 3, 4, 5: 10 bytes.
- Byte layout:
  - Register byte, when present, is byte 1.
  - Constant occupies bytes 1-8 for icode 7/8, bytes 2-9 for icode 3/4/5.
  - Constant byte i maps to valC[8i+7:8i].
- Address check, each FETCH cycle before capture:
  - If ptr >= MEM_BYTES, abort: stat=3, icode/ifun as captured so far (0 if k=0), valP=ptr.
  - mem_byte is ignored that cycle.
- Validity check on byte 0:
  - stat=4 (INS), length forced to 1, if any of:
  - icode > B;
  - icode 6 with ifun > 3;
  - icode 2/7 with ifun > 6;
  - any other icode with ifun != 0.
  - icode 0 (halt): stat=2.
- Output timing:
  - On the edge that captures the last byte (or detects an error), all fields are registered and out_valid<=1, state<=HOLD.
  - Latency: an L-byte instruction reaches out_valid L cycles after FETCH entry.
- HOLD: fields and out_valid stable while out_valid && !out_ready.
- On handshake (out_valid && out_ready):
  - If stat=1: ptr<=valP, base<=valP, k<=0, out_valid<=0, state<=FETCH.
  - Else: out_valid<=0, state<=STOP.
- STOP: no fetching until redirect or rst.
- valP and all address arithmetic are 64-bit and wrap modulo 2^64.
- No bubbles beyond the above; no overlap of consecutive fetches.

Test Plan:
- Mem[0..1]=60 22; rst, then redirect to 0 with out_ready=1 → out_valid in cycle 2; icode=6, ifun=0, rA=2, rB=2, valC=0, valP=2, stat=1.
- Mem[2..10]=80 0e 00×7, continuing from the previous instruction → after 9 cycles: icode=8, rA=rB=F, valC=0x0E, valP=11, pc_out=2.
- Mem[14..23]=30 f9 45 00×7 with out_ready=0 for 5 cycles → fields stable through HOLD; then rA=F, rB=9, valC=0x45, valP=24; next fetch starts at 24 after accept.
- Redirect to 0x40 during byte 4 of a 10-byte fetch → partial discarded, out_valid never asserted for it, mem_addr=0x40 next cycle.
- Redirect to 127 with mem[127]=0x60 → byte 0 captured, next cycle ptr=128 → stat=3, icode=6, valP=128; after accept the block enters STOP and mem_addr stays constant.
- Byte 00 (halt) → stat=2, valP=pc+1, then STOP; byte C0 → stat=4, length 1, then STOP.
